// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data side has priority; a streak counter bounds how long fetch can be starved.
module mem_port_arbiter #(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    state_t              state_q, state_d;
    logic [3:0]          d_streak_q, d_streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic                grant_d, grant_if, can_accept;

    // Handshake: a request is accepted on any cycle where its ready is high;
    // the requester holds req and its fields stable until then.
    always_comb begin
        grant_d    = d_req & (~if_req | (d_streak_q < MAX_STREAK));
        grant_if   = if_req & ~grant_d;
        can_accept = (state_q == IDLE) & clk_enable & ~rst;
        if_ready   = can_accept & grant_if;
        d_ready    = can_accept & grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_streak_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_streak_q  <= d_streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clk_enable) begin
            case (state_q)
                IDLE: begin
                    if (d_ready)       state_d = D_WAIT;
                    else if (if_ready) state_d = IF_WAIT;
                end
                IF_WAIT, D_WAIT: if (mem_ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // With clk_enable low every register holds, including a pending rvalid pulse.
    always_comb begin
        d_streak_d  = d_streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = if_rvalid_q;
        d_rvalid_d  = d_rvalid_q;
        if (clk_enable) begin
            if_rvalid_d = 1'b0;
            d_rvalid_d  = 1'b0;
            if (d_ready) begin
                mem_req_d   = 1'b1;
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                mem_wmask_d = d_we ? d_wmask : 4'h0;
                d_streak_d  = !if_req ? 4'h0 :
                              (d_streak_q == MAX_STREAK) ? MAX_STREAK : 4'(d_streak_q + 4'd1);
            end else if (if_ready) begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b0;
                mem_addr_d  = if_addr;
                mem_wmask_d = 4'h0;
                d_streak_d  = 4'h0;
            end
            if (state_q == IF_WAIT && mem_ack) begin
                mem_req_d   = 1'b0;
                if_rdata_d  = mem_rdata;
                if_rvalid_d = 1'b1;
            end
            if (state_q == D_WAIT && mem_ack) begin
                mem_req_d  = 1'b0;
                d_rvalid_d = 1'b1;
                if (!mem_we_q) d_rdata_d = mem_rdata;
            end
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW   = 30;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst, clk_enable;
    logic          if_req, d_req, d_we, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [3:0]    d_wmask;
    logic          if_ready, if_rvalid, d_ready, d_rvalid;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic          mem_req, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wmask;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: one outstanding transaction, kind 0 = fetch, 1 = load, 2 = store.
    bit            m_busy;
    int            m_kind;
    int            m_streak;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wmask;
    bit            m_rv_if, m_rv_d;
    logic [DW-1:0] m_if_rdata, m_d_rdata;
    bit            g_acc_if, g_acc_d;
    int            g_obs;  // grant seen on the DUT this cycle: 0 none, 1 data, 2 fetch

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit model_wants_d();
        return d_req && (!if_req || m_streak < MAXS);
    endfunction

    function automatic bit model_can_accept();
        return !rst && clk_enable && !m_busy;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_kind = 0; m_streak = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0;
        m_rv_if = 0; m_rv_d = 0; m_if_rdata = '0; m_d_rdata = '0;
    endtask

    // Entered just after a rising edge with inputs already driven for this cycle.
    task automatic cycle();
        bit e_if, e_d;
        #3;
        e_d  = model_can_accept() && model_wants_d();
        e_if = model_can_accept() && if_req && !model_wants_d();
        chk("if_ready", if_ready, e_if);
        chk("d_ready", d_ready, e_d);
        g_obs = d_ready ? 1 : (if_ready ? 2 : 0);
        g_acc_if = 0; g_acc_d = 0;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (clk_enable) begin
            m_rv_if = 0; m_rv_d = 0;
            if (m_busy) begin
                if (mem_ack) begin
                    m_busy = 0;
                    if (m_kind == 0) begin m_rv_if = 1; m_if_rdata = mem_rdata; end
                    else begin
                        m_rv_d = 1;
                        if (m_kind == 1) m_d_rdata = mem_rdata;
                    end
                end
            end else if (e_d) begin
                g_acc_d = 1; m_busy = 1; m_kind = d_we ? 2 : 1;
                m_addr = d_addr; m_wdata = d_wdata; m_wmask = d_we ? d_wmask : 4'h0;
                m_streak = !if_req ? 0 : (m_streak + 1 > MAXS ? MAXS : m_streak + 1);
            end else if (e_if) begin
                g_acc_if = 1; m_busy = 1; m_kind = 0;
                m_addr = if_addr; m_wmask = 4'h0; m_streak = 0;
            end
        end
        #1;
        chk("busy", busy, m_busy);
        chk("mem_req", mem_req, m_busy);
        if (m_busy) begin
            chk("mem_we", mem_we, m_kind == 2);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wmask", mem_wmask, m_wmask);
            if (m_kind != 0) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_rvalid", if_rvalid, m_rv_if);
        chk("d_rvalid", d_rvalid, m_rv_d);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("rvalid_exclusive", if_rvalid & d_rvalid, 1'b0);
    endtask

    int exp_order[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int got_order[$];

    initial begin
        rst = 1; clk_enable = 1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
        model_reset();
        #1;
        cycle(); cycle();
        rst = 0;
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_wmask", mem_wmask, 0);

        // Fetch only, ack two cycles after mem_req rises.
        if_req = 1; if_addr = 'h10; cycle();
        chk("fetch_grant", g_obs, 2);
        if_req = 0;
        chk("fetch_mem_req_c1", mem_req, 1);
        chk("fetch_mem_we", mem_we, 0);
        chk("fetch_mem_addr", mem_addr, 'h10);
        cycle();
        chk("fetch_mem_req_c2", mem_req, 1);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF; cycle();
        chk("fetch_rvalid_c3", if_rvalid, 1);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        chk("fetch_mem_req_c3", mem_req, 0);
        mem_ack = 0; cycle();
        chk("fetch_rvalid_pulse", if_rvalid, 0);

        // Store with single-cycle ack; d_rdata must not change.
        d_req = 1; d_we = 1; d_addr = 'h20; d_wdata = 32'h12345678; d_wmask = 4'hF; cycle();
        chk("store_grant", g_obs, 1);
        d_req = 0;
        chk("store_mem_we", mem_we, 1);
        chk("store_mem_wmask", mem_wmask, 4'hF);
        chk("store_mem_addr", mem_addr, 'h20);
        chk("store_mem_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0; cycle();
        chk("store_done", d_rvalid, 1);
        chk("store_d_rdata", d_rdata, 0);
        mem_ack = 0; d_we = 0; cycle();

        // Reset colliding with mem_ack abandons the load (streak had reached 1).
        if_req = 1; if_addr = 'h40; d_req = 1; d_addr = 'h44; cycle();
        chk("rst_load_grant", g_obs, 1);
        d_req = 0;
        mem_ack = 1; mem_rdata = 32'h55; rst = 1; cycle();
        chk("rst_no_rvalid", d_rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 0; if_req = 0; mem_ack = 0; cycle();
        chk("rst_no_rvalid_after", d_rvalid, 0);

        // Contention: both sides always requesting; streak must have restarted at 0.
        if_req = 1; d_req = 1; d_we = 0;
        if_addr = AW'($urandom); d_addr = AW'($urandom);
        for (int c = 0; c < 100 && got_order.size() < 10; c++) begin
            mem_ack = m_busy; mem_rdata = $urandom;
            cycle();
            if (g_obs != 0) got_order.push_back(g_obs);
            if (g_acc_if) if_addr = AW'($urandom);
            if (g_acc_d)  d_addr  = AW'($urandom);
        end
        chk("contention_count", got_order.size(), 10);
        for (int i = 0; i < 10 && i < got_order.size(); i++)
            chk($sformatf("contention_grant_%0d", i), got_order[i], exp_order[i]);
        if_req = 0; d_req = 0;
        for (int c = 0; c < 10 && (m_busy || if_rvalid || d_rvalid); c++) begin
            mem_ack = m_busy; cycle();
        end
        mem_ack = 0;
        chk("contention_drained", busy, 0);

        // Stall for three cycles in D_WAIT with mem_ack held high.
        d_req = 1; d_we = 0; d_addr = 'h80; cycle();
        d_req = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D; clk_enable = 0;
        repeat (3) begin
            cycle();
            chk("stall_busy", busy, 1);
            chk("stall_mem_req", mem_req, 1);
            chk("stall_mem_addr", mem_addr, 'h80);
            chk("stall_no_rvalid", d_rvalid, 0);
        end
        clk_enable = 1; cycle();
        chk("stall_rvalid", d_rvalid, 1);
        chk("stall_rdata", d_rdata, 32'hCAFEF00D);
        mem_ack = 0; clk_enable = 0; cycle();
        chk("stall_rvalid_held", d_rvalid, 1);
        clk_enable = 1; cycle();
        chk("stall_rvalid_drop", d_rvalid, 0);

        // Spurious ack while idle.
        mem_ack = 1;
        repeat (3) begin
            cycle();
            chk("spurious_if_rvalid", if_rvalid, 0);
            chk("spurious_d_rvalid", d_rvalid, 0);
            chk("spurious_busy", busy, 0);
        end
        mem_ack = 0;

        // Randomized traffic: stalls, rare resets, variable latency, spurious acks.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            clk_enable = ($urandom_range(0, 9) != 0);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = AW'($urandom);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = AW'($urandom);
                d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
            end
            if (m_busy) mem_ack = mem_ack | ($urandom_range(0, 2) == 0);
            else        mem_ack = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            cycle();
            if (g_acc_if) if_req = 0;
            if (g_acc_d)  d_req  = 0;
            if (!m_busy)  mem_ack = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
